// File: rtl/rv_backup_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_backup_pkg
// Description : Shared types and constants for the register backup/restore
//               sequencer: FSM state type, dirty/valid flag offsets within
//               each 2-bit entry of dirty_vals, and default dimensions.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_backup_pkg;

    // Default dimensions (3 control-unit + 50 datapath registers).
    localparam int c_DEF_NUM_REGS  = 53;
    localparam int c_DEF_DATA_W    = 32;
    localparam int c_DEF_NV_WR_LAT = 4;

    // Bit offsets of the per-entry flags inside dirty_vals[2*i +: 2].
    localparam int DIRTY_BIT = 0;
    localparam int VALID_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_BEN   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACK   = 3'd4,
        ST_RSCAN = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rv_nv_store.sv
`default_nettype none
// ============================================================================
// Module      : rv_nv_store
// Description : Retained register store. NUM_REGS entries of DATA_W bits,
//               each with a valid flag. Contents are never reset so they
//               survive a controller reset (retention model).
// Ports       : clk        - clock
//               i_clr_all  - clear every valid flag (data untouched)
//               i_wr_en    - write i_wr_data into entry i_wr_idx, set valid
//               i_inv_en   - clear valid flag of entry i_inv_idx
//               o_valid    - per-entry valid flags
//               o_rd_data  - flat read-out, entry i at [DATA_W*i +: DATA_W]
// Revision    : 1.0 - initial release
// ============================================================================
module rv_nv_store #(
    parameter int NUM_REGS = 53,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 6
) (
    input  logic                       clk,
    input  logic                       i_clr_all,
    input  logic                       i_wr_en,
    input  logic [IDX_W-1:0]           i_wr_idx,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_inv_en,
    input  logic [IDX_W-1:0]           i_inv_idx,
    output logic [NUM_REGS-1:0]        o_valid,
    output logic [DATA_W*NUM_REGS-1:0] o_rd_data
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            logic              r_valid;
            logic [DATA_W-1:0] r_data;
            logic              w_wr_hit;
            logic              w_inv_hit;

            assign w_wr_hit  = i_wr_en  && (i_wr_idx  == IDX_W'(gi));
            assign w_inv_hit = i_inv_en && (i_inv_idx == IDX_W'(gi));

            // No reset on purpose: data and flags model retained storage.
            always_ff @(posedge clk) begin
                if (w_wr_hit) begin
                    r_data <= i_wr_data;
                end
                if (i_clr_all) begin
                    r_valid <= 1'b0;
                end else if (w_wr_hit) begin
                    r_valid <= 1'b1;
                end else if (w_inv_hit) begin
                    r_valid <= 1'b0;
                end
            end

            assign o_valid[gi]                      = r_valid;
            assign o_rd_data[DATA_W*gi +: DATA_W]   = r_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rv_backup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv_backup_ctrl
// Description : Backup/restore sequencer for the core's register backup
//               interface. A backup scans every entry, copies the selected
//               ones into the retained store with a strobe / wait / ack
//               handshake; a restore strobes restore_ens for every entry the
//               store holds as valid. The core is held in stand-by meanwhile.
// Build option: RV_BACKUP_SKIP_CLEAN_EN defined  -> incremental backup
//               (only dirty+valid entries); undefined -> full checkpoint
//               (every valid entry).
// Ports       : Clk, Rst (sync, active-low)
//               backup_req / restore_req / nv_clr - level, sampled in IDLE
//               dirty_vals    - per entry {valid, dirty}
//               backup_Vouts  - core register values (flat)
//               backup_ens / backup_acks / restore_ens - one-hot strobes
//               restore_Vins  - store contents (flat)
//               stand_by, busy - high whenever not IDLE
//               done          - one-cycle pulse at sequence end
// Revision    : 1.0 - initial release
// ============================================================================
module rv_backup_ctrl
    import rv_backup_pkg::*;
#(
    parameter int NUM_REGS  = c_DEF_NUM_REGS,
    parameter int DATA_W    = c_DEF_DATA_W,
    parameter int NV_WR_LAT = c_DEF_NV_WR_LAT
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       backup_req,
    input  logic                       restore_req,
    input  logic                       nv_clr,
    input  logic [2*NUM_REGS-1:0]      dirty_vals,
    input  logic [DATA_W*NUM_REGS-1:0] backup_Vouts,
    output logic [NUM_REGS-1:0]        backup_ens,
    output logic [NUM_REGS-1:0]        backup_acks,
    output logic [NUM_REGS-1:0]        restore_ens,
    output logic [DATA_W*NUM_REGS-1:0] restore_Vins,
    output logic                       stand_by,
    output logic                       busy,
    output logic                       done
);

    localparam int c_IDX_W = (NUM_REGS  > 1) ? $clog2(NUM_REGS)  : 1;
    localparam int c_CNT_W = (NV_WR_LAT > 1) ? $clog2(NV_WR_LAT) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REGS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NV_WR_LAT - 1);

    state_t               r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [c_CNT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;

    logic [NUM_REGS-1:0]  w_valid_bits;
    logic [NUM_REGS-1:0]  w_dirty_bits;
    logic [DATA_W-1:0]    w_vout [NUM_REGS];
    logic [NUM_REGS-1:0]  w_st_valid;

    logic w_valid_cur;
    logic w_sel;
    logic w_last;
    logic w_st_wr;
    logic w_st_inv;
    logic w_st_clr;

    // Unpack flat core-side buses into per-entry views.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
            assign w_valid_bits[gi] = dirty_vals[2*gi + VALID_BIT];
            assign w_dirty_bits[gi] = dirty_vals[2*gi + DIRTY_BIT];
            assign w_vout[gi]       = backup_Vouts[DATA_W*gi +: DATA_W];
        end
    endgenerate

    assign w_valid_cur = w_valid_bits[r_idx];
    assign w_last      = (r_idx == c_LAST_IDX);

`ifdef RV_BACKUP_SKIP_CLEAN_EN
    // Incremental: clean entries already match the store.
    assign w_sel = w_valid_cur & w_dirty_bits[r_idx];
`else
    // Full checkpoint: dirty flags are not consulted.
    logic w_unused_dirty;
    assign w_unused_dirty = ^w_dirty_bits;
    assign w_sel          = w_valid_cur;
`endif

    rv_nv_store #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (c_IDX_W)
    ) u_store (
        .clk       (Clk),
        .i_clr_all (w_st_clr),
        .i_wr_en   (w_st_wr),
        .i_wr_idx  (r_idx),
        .i_wr_data (w_vout[r_idx]),
        .i_inv_en  (w_st_inv),
        .i_inv_idx (r_idx),
        .o_valid   (w_st_valid),
        .o_rd_data (restore_Vins)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_wait_cnt_nxt = r_wait_cnt;
        w_st_wr        = 1'b0;
        w_st_inv       = 1'b0;
        w_st_clr       = 1'b0;
        backup_ens     = '0;
        backup_acks    = '0;
        restore_ens    = '0;
        done           = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_idx_nxt = '0;
                // A clear coinciding with a request still lets the request in.
                w_st_clr  = nv_clr;
                if (backup_req) begin
                    w_state_nxt = ST_SCAN;
                end else if (restore_req) begin
                    w_state_nxt = ST_RSCAN;
                end
            end

            ST_SCAN: begin
                // An entry the core reports as invalid must not be restored.
                w_st_inv = !w_valid_cur;
                if (w_sel) begin
                    w_state_nxt = ST_BEN;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end

            ST_BEN: begin
                backup_ens[r_idx] = 1'b1;
                w_st_wr           = 1'b1;
                w_wait_cnt_nxt    = '0;
                w_state_nxt       = ST_WAIT;
            end

            ST_WAIT: begin
                if (r_wait_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end

            ST_ACK: begin
                backup_acks[r_idx] = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end

            ST_RSCAN: begin
                restore_ens[r_idx] = w_st_valid[r_idx];
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end

            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign stand_by = (r_state != ST_IDLE);
    assign busy     = stand_by;

endmodule
`default_nettype wire

// File: tb/tb_rv_backup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_backup_ctrl
// Description : Self-checking bench for rv_backup_ctrl. A reference model of
//               the retained store plus a per-cycle expected timeline of the
//               strobes is derived from the sequencing rules with plain
//               cycle arithmetic; every cycle of every sequence is compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_backup_ctrl;

    localparam int NR   = 53;
    localparam int DW   = 32;
    localparam int LAT  = 4;
    localparam int MAXC = 400;
    localparam int VW   = 3*NR + 3;

    logic              Clk;
    logic              Rst;
    logic              backup_req;
    logic              restore_req;
    logic              nv_clr;
    logic [2*NR-1:0]   dirty_vals;
    logic [DW*NR-1:0]  backup_Vouts;
    logic [NR-1:0]     backup_ens;
    logic [NR-1:0]     backup_acks;
    logic [NR-1:0]     restore_ens;
    logic [DW*NR-1:0]  restore_Vins;
    logic              stand_by;
    logic              busy;
    logic              done;

    rv_backup_ctrl #(
        .NUM_REGS  (NR),
        .DATA_W    (DW),
        .NV_WR_LAT (LAT)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .backup_req   (backup_req),
        .restore_req  (restore_req),
        .nv_clr       (nv_clr),
        .dirty_vals   (dirty_vals),
        .backup_Vouts (backup_Vouts),
        .backup_ens   (backup_ens),
        .backup_acks  (backup_acks),
        .restore_ens  (restore_ens),
        .restore_Vins (restore_Vins),
        .stand_by     (stand_by),
        .busy         (busy),
        .done         (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model of the store and the expected per-cycle strobes.
    logic [DW-1:0] m_data  [NR];
    bit            m_valid [NR];
    logic [DW-1:0] vals    [NR];
    logic [NR-1:0] e_ben   [MAXC+1];
    logic [NR-1:0] e_ack   [MAXC+1];
    logic [NR-1:0] e_ren   [MAXC+1];
    int            e_len;
    int            n_cmp = 0;
    int            n_mis = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_timeline();
        for (int k = 0; k <= MAXC; k++) begin
            e_ben[k] = '0;
            e_ack[k] = '0;
            e_ren[k] = '0;
        end
    endtask

    task automatic drive_core();
        for (int i = 0; i < NR; i++) backup_Vouts[DW*i +: DW] = vals[i];
    endtask

    // Cycle 1 is the first cycle after the request edge. A scanned entry
    // costs one cycle; a backed-up one costs scan + strobe + LAT + ack.
    task automatic build_backup(input int last_entry);
        int c;
        bit v, d, sel;
        clear_timeline();
        c = 1;
        for (int i = 0; i <= last_entry; i++) begin
            v = dirty_vals[2*i+1];
            d = dirty_vals[2*i];
`ifdef RV_BACKUP_SKIP_CLEAN_EN
            sel = v && d;
`else
            sel = v;
`endif
            if (sel) begin
                e_ben[c+1][i]     = 1'b1;
                e_ack[c+2+LAT][i] = 1'b1;
                m_data[i]  = vals[i];
                m_valid[i] = 1'b1;
                c += 3 + LAT;
            end else begin
                if (!v) m_valid[i] = 1'b0;
                c += 1;
            end
        end
        e_len = c;
    endtask

    task automatic build_restore();
        clear_timeline();
        for (int i = 0; i < NR; i++) begin
            if (m_valid[i]) e_ren[i+1][i] = 1'b1;
        end
        e_len = NR + 1;
    endtask

    // Compares cycles 1..n; returns at the falling edge of cycle n.
    task automatic check_cycles(input int n, input string tag);
        logic [VW-1:0] obs, exp;
        for (int k = 1; k <= n; k++) begin
            @(negedge Clk);
            exp = {e_ben[k], e_ack[k], e_ren[k], 1'b1, 1'b1, (k == e_len)};
            obs = {backup_ens, backup_acks, restore_ens, stand_by, busy, done};
            n_cmp++;
            assert (obs === exp) else begin
                n_mis++;
                $error("FAIL %s cycle %0d: observed %h expected %h", tag, k, obs, exp);
            end
            if (k < n) tick();
        end
    endtask

    task automatic check_idle(input string tag);
        logic [VW-1:0] obs;
        @(negedge Clk);
        obs = {backup_ens, backup_acks, restore_ens, stand_by, busy, done};
        n_cmp++;
        assert (obs === '0) else begin
            n_mis++;
            $error("FAIL %s idle: observed %h expected 0", tag, obs);
        end
    endtask

    task automatic check_store(input string tag);
        for (int i = 0; i < NR; i++) begin
            if (m_valid[i]) begin
                n_cmp++;
                assert (restore_Vins[DW*i +: DW] === m_data[i]) else begin
                    n_mis++;
                    $error("FAIL %s entry %0d: observed %h expected %h",
                           tag, i, restore_Vins[DW*i +: DW], m_data[i]);
                end
            end
        end
    endtask

    task automatic run_backup(input string tag);
        drive_core();
        build_backup(NR-1);
        backup_req = 1'b1;
        tick();
        backup_req = 1'b0;
        check_cycles(e_len, tag);
        tick();
        check_idle(tag);
        check_store(tag);
    endtask

    task automatic run_restore(input string tag, input bit clr);
        if (clr) for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
        build_restore();
        restore_req = 1'b1;
        nv_clr      = clr;
        tick();
        restore_req = 1'b0;
        nv_clr      = 1'b0;
        check_cycles(e_len, tag);
        tick();
        check_idle(tag);
    endtask

    task automatic random_core();
        for (int i = 0; i < NR; i++) begin
            dirty_vals[2*i]   = 1'($urandom_range(0, 1));
            dirty_vals[2*i+1] = ($urandom_range(0, 3) != 0);
            vals[i]           = $urandom;
        end
    endtask

    initial begin
        Rst          = 1'b0;
        backup_req   = 1'b0;
        restore_req  = 1'b0;
        nv_clr       = 1'b0;
        dirty_vals   = '0;
        backup_Vouts = '0;
        for (int i = 0; i < NR; i++) begin
            vals[i]    = '0;
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
        end

        // Reset state.
        tick();
        tick();
        check_idle("reset");
        Rst = 1'b1;
        tick();

        // Clear coinciding with restore: 53 empty RSCAN cycles, done on 54.
        run_restore("clr_restore", 1'b1);

        // Entries 0 and 52 dirty+valid, the rest valid+clean.
        for (int i = 0; i < NR; i++) begin
            dirty_vals[2*i+1] = 1'b1;
            dirty_vals[2*i]   = (i == 0 || i == NR-1);
            vals[i]           = $urandom;
        end
        run_backup("ends_dirty");
        run_restore("ends_restore", 1'b0);

        // Entry 5 retained across a reset.
        dirty_vals = '0;
        dirty_vals[11] = 1'b1;
        dirty_vals[10] = 1'b1;
        for (int i = 0; i < NR; i++) vals[i] = $urandom;
        vals[5] = 32'hDEADBEEF;
        run_backup("e5_backup");
        Rst = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
        check_idle("e5_reset");
        run_restore("e5_restore", 1'b0);
        n_cmp++;
        assert (restore_Vins[191:160] === 32'hDEADBEEF) else begin
            n_mis++;
            $error("FAIL e5_value: observed %h expected deadbeef", restore_Vins[191:160]);
        end

        // Both requests together; restore held during busy is taken only later.
        random_core();
        drive_core();
        build_backup(NR-1);
        backup_req  = 1'b1;
        restore_req = 1'b1;
        tick();
        backup_req  = 1'b0;
        check_cycles(e_len, "both_backup");
        tick();
        check_idle("both_idle");
        check_store("both_store");
        build_restore();
        tick();
        restore_req = 1'b0;
        check_cycles(e_len, "both_restore");
        tick();
        check_idle("both_end");

        // Reset during WAIT of entry 10: entries 0..9 invalid, 10 dirty+valid.
        dirty_vals = '0;
        dirty_vals[21] = 1'b1;
        dirty_vals[20] = 1'b1;
        for (int i = 0; i < NR; i++) vals[i] = $urandom;
        drive_core();
        build_backup(10);
        backup_req = 1'b1;
        tick();
        backup_req = 1'b0;
        check_cycles(14, "abort_run");
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        check_idle("abort_reset");
        for (int k = 0; k < 8; k++) begin
            tick();
            check_idle("abort_quiet");
        end
        check_store("abort_store");
        run_restore("abort_restore", 1'b0);

        // All entries valid+clean.
        for (int i = 0; i < NR; i++) begin
            dirty_vals[2*i+1] = 1'b1;
            dirty_vals[2*i]   = 1'b0;
            vals[i]           = $urandom;
        end
        run_backup("all_clean");
        run_restore("all_clean_restore", 1'b0);

        // Random rounds.
        for (int r = 0; r < 3; r++) begin
            random_core();
            run_backup("rand_backup");
            run_restore("rand_restore", 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
